// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command engine: command targets, FSM states,
// sticky error flag positions and the status byte layout.
package spi_cmd_pkg;

  typedef enum logic [1:0] {
    TGT_REG  = 2'b00,
    TGT_FIFO = 2'b01,
    TGT_RAM  = 2'b10,
    TGT_STAT = 2'b11
  } target_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_WDATA,
    S_RDATA
  } state_e;

  localparam int unsigned ERR_OVF = 0;
  localparam int unsigned ERR_UDF = 1;
  localparam int unsigned ERR_BAD = 2;

  function automatic logic [7:0] status_byte(input logic full, input logic empty,
                                             input logic [2:0] err);
    return {3'b000, full, empty, err};
  endfunction

endpackage

// File: rtl/spi_word_pack.sv
// Byte<->word assembler/serialiser: tracks the byte position inside a word and
// maps it to a lane according to the wire endianness.
module spi_word_pack #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned BIG_ENDIAN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              byte_en,
  input  logic [7:0]        byte_in,
  input  logic [DATA_W-1:0] word_out,
  output logic              first,
  output logic              last,
  output logic [DATA_W-1:0] word_in,
  output logic [7:0]        byte_out
);
  localparam int unsigned WB = DATA_W / 8;

  logic [1:0]        cnt;
  logic [1:0]        pos;
  logic [4:0]        off;
  logic [DATA_W-1:0] acc;

  assign first = (cnt == 2'd0);
  assign last  = (cnt == 2'(WB - 1));
  assign pos   = (BIG_ENDIAN != 0) ? (2'(WB - 1) - cnt) : cnt;
  assign off   = {pos, 3'b000};

  // Incoming byte merged into the partial word so the completed word is
  // available in the same cycle as the last byte's rx_valid.
  always_comb begin
    word_in          = acc;
    word_in[off +: 8] = byte_in;
  end

  assign byte_out = word_out[off +: 8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (byte_en) begin
      acc <= word_in;
      cnt <= last ? 2'd0 : cnt + 2'd1;
    end
  end

endmodule

// File: rtl/spi_cmd_engine.sv
// SPI command engine: decodes the command byte and streams words between the
// SPI byte interface and the register bank, status inputs, FIFO and RAM ports.
module spi_cmd_engine
  import spi_cmd_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned NUM_REGS   = 4,
  parameter int unsigned NUM_STAT   = 2,
  parameter int unsigned RAM_AW     = 8,
  parameter int unsigned RAM_RD_LAT = 2,
  parameter int unsigned BIG_ENDIAN = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_sel,
  input  logic                         rx_valid,
  input  logic [7:0]                   rx_data,
  output logic [7:0]                   tx_data,
  output logic [NUM_REGS*DATA_W-1:0]   o_regs,
  input  logic [NUM_STAT*DATA_W-1:0]   i_stat,
  output logic                         fifo_wreq,
  output logic [DATA_W-1:0]            fifo_wdata,
  input  logic                         fifo_wfull,
  output logic                         fifo_rreq,
  input  logic [DATA_W-1:0]            fifo_rdata,
  input  logic                         fifo_rempty,
  output logic                         ram_wreq,
  output logic [RAM_AW-1:0]            ram_waddr,
  output logic [DATA_W-1:0]            ram_wdata,
  output logic [RAM_AW-1:0]            ram_raddr,
  input  logic [DATA_W-1:0]            ram_rdata,
  output logic [2:0]                   err_flags
);
  localparam int unsigned WB       = DATA_W / 8;
  localparam int unsigned AB       = (RAM_AW + 7) / 8;
  localparam logic [7:0]  RAM_FCNT = 8'(RAM_RD_LAT + 1);

  state_e            state, state_next;
  target_e           tgt, cmd_tgt, fetch_tgt;
  logic              cmd_rd;
  logic [4:0]        idx;
  logic [RAM_AW-1:0] addr, addr_next;
  logic [7:0]        addr_hi;
  logic [1:0]        addr_cnt;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [7:0]        fetch_cnt, fcnt_init;
  logic              fifo_miss;
  logic [DATA_W-1:0] cur_word, pend_word, rd_word, fetched, pk_word;
  logic              cur_valid, pend_valid;
  logic [2:0]        err_set, err_clr;
  logic [7:0]        pk_byte;
  logic              pk_first, pk_last, pk_clr;
  logic              cmd_ev, addr_ev, addr_done, data_ev, wword, rd_first, rd_last;
  logic              fetch_start_init, fetch_start, capture;

  spi_word_pack #(
    .DATA_W     (DATA_W),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_pack (
    .clk      (clk),
    .rst      (rst),
    .clr      (pk_clr),
    .byte_en  (data_ev),
    .byte_in  (rx_data),
    .word_out (cur_word),
    .first    (pk_first),
    .last     (pk_last),
    .word_in  (pk_word),
    .byte_out (pk_byte)
  );

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_oregs
    assign o_regs[g*DATA_W +: DATA_W] = regs[g];
  end

  assign cmd_tgt   = target_e'(rx_data[6:5]);
  assign addr_next = RAM_AW'({addr_hi, rx_data});
  assign ram_raddr = addr;
  assign pk_clr    = (state != S_WDATA) && (state != S_RDATA);

  assign cmd_ev    = frame_sel && rx_valid && (state == S_CMD);
  assign addr_ev   = frame_sel && rx_valid && (state == S_ADDR);
  assign addr_done = addr_ev && (addr_cnt == 2'(AB - 1));
  assign data_ev   = frame_sel && rx_valid && !pk_clr;
  assign wword     = data_ev && (state == S_WDATA) && pk_last;
  assign rd_first  = data_ev && (state == S_RDATA) && pk_first;
  assign rd_last   = data_ev && (state == S_RDATA) && pk_last;

  assign fetch_start_init = (cmd_ev && rx_data[7] && (cmd_tgt != TGT_RAM)) ||
                            (addr_done && cmd_rd);
  assign fetch_start      = fetch_start_init || rd_first;
  assign fetch_tgt        = cmd_ev ? cmd_tgt : tgt;
  assign capture          = frame_sel && (state == S_RDATA) && (fetch_cnt == 8'd1);

  assign tx_data = ((state == S_RDATA) && cur_valid) ? pk_byte : 8'h00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  state_next = S_CMD;
      S_CMD:   if (rx_valid) state_next = (cmd_tgt == TGT_RAM) ? S_ADDR :
                                          (rx_data[7] ? S_RDATA : S_WDATA);
      S_ADDR:  if (addr_done) state_next = cmd_rd ? S_RDATA : S_WDATA;
      default: state_next = state;
    endcase
    if (!frame_sel) state_next = S_IDLE;
  end

  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      if (idx == 5'(i)) rd_word = regs[i];
    for (int unsigned j = 0; j < NUM_STAT; j++)
      if (idx == 5'(NUM_REGS + j)) rd_word = i_stat[j*DATA_W +: DATA_W];
  end

  always_comb begin
    case (tgt)
      TGT_REG:  fetched = rd_word;
      TGT_FIFO: fetched = fifo_miss ? '0 : fifo_rdata;
      TGT_RAM:  fetched = ram_rdata;
      default:  fetched = {WB{status_byte(fifo_wfull, fifo_rempty, err_flags)}};
    endcase
    case (fetch_tgt)
      TGT_FIFO: fcnt_init = 8'd2;
      TGT_RAM:  fcnt_init = RAM_FCNT;
      default:  fcnt_init = 8'd1;
    endcase
  end

  always_comb begin
    err_set = '0;
    err_clr = '0;
    if (wword && (tgt == TGT_REG) && (32'(idx) >= NUM_REGS)) err_set[ERR_BAD] = 1'b1;
    if (wword && (tgt == TGT_FIFO) && fifo_wfull)            err_set[ERR_OVF] = 1'b1;
    if (fetch_start && (fetch_tgt == TGT_FIFO) && fifo_rempty) err_set[ERR_UDF] = 1'b1;
    if (data_ev && (state == S_WDATA) && (tgt == TGT_STAT))  err_clr = rx_data[2:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      tgt <= TGT_REG; cmd_rd <= 1'b0; idx <= '0; addr <= '0; addr_hi <= '0; addr_cnt <= '0;
      fifo_wreq <= 1'b0; fifo_wdata <= '0; fifo_rreq <= 1'b0; fifo_miss <= 1'b0;
      ram_wreq <= 1'b0; ram_waddr <= '0; ram_wdata <= '0; err_flags <= '0;
      fetch_cnt <= '0; cur_word <= '0; pend_word <= '0; cur_valid <= 1'b0; pend_valid <= 1'b0;
    end else begin
      fifo_wreq <= 1'b0;
      ram_wreq  <= 1'b0;
      fifo_rreq <= 1'b0;
      err_flags <= (err_flags & ~err_clr) | err_set;
      if (cmd_ev) begin
        tgt <= cmd_tgt; cmd_rd <= rx_data[7]; idx <= rx_data[4:0];
        addr_hi <= '0; addr_cnt <= '0;
      end
      if (addr_ev) begin addr_hi <= rx_data; addr_cnt <= addr_cnt + 2'd1; end
      if (addr_done) addr <= addr_next;
      if (wword) begin
        case (tgt)
          TGT_REG: begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
              if (idx == 5'(i)) regs[i] <= pk_word;
            idx <= idx + 5'd1;
          end
          TGT_FIFO: if (!fifo_wfull) begin fifo_wreq <= 1'b1; fifo_wdata <= pk_word; end
          TGT_RAM: begin
            ram_wreq <= 1'b1; ram_waddr <= addr; ram_wdata <= pk_word; addr <= addr + 1'b1;
          end
          default: ;
        endcase
      end
      if (rd_first) begin idx <= idx + 5'd1; addr <= addr + 1'b1; end
      if (fetch_start) begin
        fetch_cnt <= fcnt_init;
        if (fetch_tgt == TGT_FIFO) begin fifo_rreq <= !fifo_rempty; fifo_miss <= fifo_rempty; end
      end else if (fetch_cnt != 8'd0) begin
        fetch_cnt <= fetch_cnt - 8'd1;
      end
      if (fetch_start_init) begin cur_valid <= 1'b0; pend_valid <= 1'b0; end
      // The word being shifted out stays in cur_word; a prefetched word waits
      // in pend_word until the current word's last byte has gone.
      if (capture) begin
        if (cur_valid) begin pend_word <= fetched; pend_valid <= 1'b1; end
        else           begin cur_word  <= fetched; cur_valid  <= 1'b1; end
      end
      if (rd_last) begin
        if (pend_valid) begin cur_word <= pend_word; pend_valid <= 1'b0; end
        else            cur_valid <= 1'b0;
      end
      if (!frame_sel) begin fetch_cnt <= '0; cur_valid <= 1'b0; pend_valid <= 1'b0; end
    end
  end

endmodule

// File: tb/tb_spi_cmd_engine.sv
// Directed bench for spi_cmd_engine: 16-bit big-endian instance plus a
// 32-bit little-endian instance, with simple RAM and FIFO models.
module tb_spi_cmd_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        frame_sel = 1'b0, rx_valid = 1'b0;
  logic [7:0]  rx_data = '0, tx_data;
  logic [63:0] o_regs;
  logic [31:0] i_stat = {16'hBEEF, 16'hCAFE};
  logic        fifo_wreq, fifo_wfull = 1'b0, fifo_rreq, fifo_rempty = 1'b1;
  logic [15:0] fifo_wdata, fifo_rdata = '0;
  logic        ram_wreq;
  logic [7:0]  ram_waddr, ram_raddr;
  logic [15:0] ram_wdata, ram_rdata = '0;
  logic [2:0]  err_flags;

  logic         frame_sel2 = 1'b0, rx_valid2 = 1'b0;
  logic [7:0]   rx_data2 = '0, tx_data2;
  logic [127:0] o_regs2;
  logic [63:0]  i_stat2 = '0;
  logic         fifo_wreq2, fifo_rreq2, ram_wreq2;
  logic [31:0]  fifo_wdata2, ram_wdata2;
  logic [31:0]  zero32 = '0;
  logic [7:0]   ram_waddr2, ram_raddr2;
  logic [2:0]   err_flags2;

  spi_cmd_engine dut (
    .clk(clk), .rst(rst), .frame_sel(frame_sel), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_data(tx_data), .o_regs(o_regs), .i_stat(i_stat),
    .fifo_wreq(fifo_wreq), .fifo_wdata(fifo_wdata), .fifo_wfull(fifo_wfull),
    .fifo_rreq(fifo_rreq), .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty),
    .ram_wreq(ram_wreq), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .err_flags(err_flags)
  );

  spi_cmd_engine #(.DATA_W(32), .BIG_ENDIAN(0)) dut32 (
    .clk(clk), .rst(rst), .frame_sel(frame_sel2), .rx_valid(rx_valid2), .rx_data(rx_data2),
    .tx_data(tx_data2), .o_regs(o_regs2), .i_stat(i_stat2),
    .fifo_wreq(fifo_wreq2), .fifo_wdata(fifo_wdata2), .fifo_wfull(1'b0),
    .fifo_rreq(fifo_rreq2), .fifo_rdata(zero32), .fifo_rempty(1'b1),
    .ram_wreq(ram_wreq2), .ram_waddr(ram_waddr2), .ram_wdata(ram_wdata2),
    .ram_raddr(ram_raddr2), .ram_rdata(zero32), .err_flags(err_flags2)
  );

  // RAM with two registered read stages, FIFO returning a fixed word, strobe logs.
  logic [15:0] mem [256];
  logic [15:0] rd_p1;
  logic [7:0]  wlog_a [8];
  logic [15:0] wlog_d [8];
  int n_ramw = 0, n_fw = 0, n_fr = 0;
  logic [15:0] last_fw = '0;

  always @(posedge clk) begin
    rd_p1     <= mem[ram_raddr];
    ram_rdata <= rd_p1;
    if (ram_wreq) begin
      mem[ram_waddr]     <= ram_wdata;
      wlog_a[n_ramw % 8] <= ram_waddr;
      wlog_d[n_ramw % 8] <= ram_wdata;
      n_ramw <= n_ramw + 1;
    end
    if (fifo_wreq) begin n_fw <= n_fw + 1; last_fw <= fifo_wdata; end
    if (fifo_rreq) begin n_fr <= n_fr + 1; fifo_rdata <= 16'h5AC3; end
  end

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input int d, input logic [7:0] b, output logic [7:0] t);
    @(negedge clk);
    if (d == 0) begin t = tx_data;  rx_data  = b; rx_valid  = 1'b1; end
    else        begin t = tx_data2; rx_data2 = b; rx_valid2 = 1'b1; end
    @(negedge clk);
    rx_valid  = 1'b0;
    rx_valid2 = 1'b0;
    repeat (7) @(negedge clk);
  endtask

  task automatic frame_on(input int d);
    @(negedge clk);
    if (d == 0) frame_sel = 1'b1; else frame_sel2 = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic frame_off(input int d);
    @(negedge clk);
    if (d == 0) frame_sel = 1'b0; else frame_sel2 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] t;
  logic [7:0] exp6 [6];
  logic [7:0] exp4 [4];
  int base;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_oregs", o_regs, 64'h0);
    check("rst_err", err_flags, 3'b000);
    check("rst_tx", tx_data, 8'h00);
    check("rst_strobes", {fifo_wreq, fifo_rreq, ram_wreq}, 3'b000);
    check("rst_raddr", ram_raddr, 8'h00);
    check("rst_oregs32", o_regs2, 128'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    frame_on(0); send(0, 8'h02, t); send(0, 8'h12, t); send(0, 8'h34, t); frame_off(0);
    check("reg2_write", o_regs, 64'h0000_1234_0000_0000);
    frame_on(0); send(0, 8'h82, t);
    check("tx_cmd_byte", t, 8'h00);
    send(0, 8'h00, t); check("reg2_rd_b0", t, 8'h12);
    send(0, 8'h00, t); check("reg2_rd_b1", t, 8'h34);
    frame_off(0);

    exp6 = '{8'hCA, 8'hFE, 8'hBE, 8'hEF, 8'h00, 8'h00};
    frame_on(0); send(0, 8'h84, t);
    for (int i = 0; i < 6; i++) begin
      send(0, 8'h00, t);
      check($sformatf("stat_rd_b%0d", i), t, exp6[i]);
    end
    frame_off(0);

    base = n_ramw;
    frame_on(0);
    send(0, 8'h40, t); send(0, 8'hFE, t);
    send(0, 8'hAA, t); send(0, 8'hAA, t); send(0, 8'hBB, t); send(0, 8'hBB, t);
    send(0, 8'hCC, t); send(0, 8'hCC, t);
    frame_off(0);
    check("ram_wreq_cnt", n_ramw - base, 3);
    check("ram_waddr0", wlog_a[(base + 0) % 8], 8'hFE);
    check("ram_waddr1", wlog_a[(base + 1) % 8], 8'hFF);
    check("ram_waddr2", wlog_a[(base + 2) % 8], 8'h00);
    check("ram_wdata2", wlog_d[(base + 2) % 8], 16'hCCCC);

    exp4 = '{8'hBB, 8'hBB, 8'hCC, 8'hCC};
    frame_on(0); send(0, 8'hC0, t); send(0, 8'hFF, t);
    check("tx_addr_byte", t, 8'h00);
    for (int i = 0; i < 4; i++) begin
      send(0, 8'h00, t);
      check($sformatf("ram_rd_b%0d", i), t, exp4[i]);
    end
    frame_off(0);

    base = n_fw;
    frame_on(0);
    send(0, 8'h20, t); send(0, 8'h11, t); send(0, 8'h11, t); send(0, 8'h22, t); send(0, 8'h22, t);
    fifo_wfull = 1'b1;
    send(0, 8'h33, t); send(0, 8'h33, t);
    frame_off(0);
    fifo_wfull = 1'b0;
    check("fifo_wreq_cnt", n_fw - base, 2);
    check("fifo_wdata", last_fw, 16'h2222);
    check("err_ovf", err_flags, 3'b001);

    base = n_fr;
    fifo_rempty = 1'b1;
    frame_on(0); send(0, 8'hA0, t);
    send(0, 8'h00, t); check("fifo_udf_b0", t, 8'h00);
    send(0, 8'h00, t); check("fifo_udf_b1", t, 8'h00);
    frame_off(0);
    check("fifo_udf_rreq", n_fr - base, 0);
    check("err_udf", err_flags, 3'b011);

    base = n_fr;
    fifo_rempty = 1'b0;
    frame_on(0); send(0, 8'hA0, t);
    send(0, 8'h00, t); check("fifo_rd_b0", t, 8'h5A);
    send(0, 8'h00, t); check("fifo_rd_b1", t, 8'hC3);
    frame_off(0);
    fifo_rempty = 1'b1;
    check("fifo_rreq_cnt", n_fr - base, 2);

    frame_on(0); send(0, 8'h05, t); send(0, 8'hDE, t); send(0, 8'hAD, t); frame_off(0);
    check("err_bad", err_flags, 3'b111);
    check("bad_oregs", o_regs, 64'h0000_1234_0000_0000);

    frame_on(0); send(0, 8'hE0, t);
    send(0, 8'h00, t); check("status_b0", t, 8'h0F);
    send(0, 8'h00, t); check("status_b1", t, 8'h0F);
    frame_off(0);
    frame_on(0); send(0, 8'h60, t); send(0, 8'h07, t); frame_off(0);
    check("err_w1c", err_flags, 3'b000);

    base = n_ramw;
    frame_on(0); send(0, 8'h40, t); send(0, 8'h10, t); send(0, 8'h55, t); frame_off(0);
    check("partial_no_wreq", n_ramw - base, 0);
    frame_on(0); send(0, 8'h01, t); send(0, 8'h9A, t); send(0, 8'hBC, t); frame_off(0);
    check("reg1_after_drop", o_regs, 64'h0000_1234_9ABC_0000);

    frame_on(0); send(0, 8'h05, t); send(0, 8'h01, t); send(0, 8'h02, t); frame_off(0);
    frame_on(0); send(0, 8'h00, t); send(0, 8'hAA, t);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_oregs", o_regs, 64'h0);
    check("arst_err", err_flags, 3'b000);
    check("arst_tx", tx_data, 8'h00);
    frame_sel = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    frame_on(1);
    send(1, 8'h02, t); send(1, 8'h78, t); send(1, 8'h56, t); send(1, 8'h34, t); send(1, 8'h12, t);
    frame_off(1);
    check("w32_reg2", o_regs2[95:64], 32'h1234_5678);
    exp4 = '{8'h78, 8'h56, 8'h34, 8'h12};
    frame_on(1); send(1, 8'h82, t);
    for (int i = 0; i < 4; i++) begin
      send(1, 8'h00, t);
      check($sformatf("w32_rd_b%0d", i), t, exp4[i]);
    end
    frame_off(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
